fetch_queue: RTL

Instruction prefetch queue that sits directly upstream of the CPU decode stage. It issues sequential 19-bit instruction fetches to instruction memory through a request/response handshake. Returned words are buffered with their PC in a small FIFO, which feeds decode through a valid/ready interface. A redirect from jump/branch resolution flushes the queue, discards any in-flight fetch and restarts fetching at the new PC.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and decode.
// Issues sequential fetches (at most one outstanding), buffers each returned word
// with its PC in a DEPTH-entry FIFO, and presents the FIFO head to decode.
// A redirect flushes the FIFO, marks any in-flight fetch stale and restarts at
// redirect_pc.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   redirect_valid/_pc       flush and restart fetch at redirect_pc
//   mem_req/mem_addr         fetch request and address (addr = fetch_pc)
//   mem_ready                memory accepts the request this cycle
//   mem_rvalid/mem_rdata     fetch response
//   inst_valid/_data/_pc     FIFO head towards decode
//   inst_ready               decode consumes the head
//   count                    number of occupied FIFO entries
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // state   | meaning
  // FETCH   | no fetch outstanding
  // WAIT    | one fetch outstanding, response will be pushed
  // DISCARD | one fetch outstanding, response will be dropped
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d   [DEPTH];
  logic [DATA_W-1:0]   data_mem_q [DEPTH];
  logic [DATA_W-1:0]   data_mem_d [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // rst gates mem_req so the request drops the moment reset is applied.
  assign mem_req    = !rst && (state_q == ST_FETCH) && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
  assign mem_addr   = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign count      = count_q;

  assign accept = mem_req && mem_ready;
  assign push   = (state_q == ST_WAIT) && mem_rvalid && !redirect_valid;
  assign pop    = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // An outstanding fetch becomes stale unless its response lands right now.
      if (state_q != ST_FETCH) begin
        state_d = mem_rvalid ? ST_FETCH : ST_DISCARD;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (mem_rvalid) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase

      if (push) begin
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        data_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

endmodule
